hazard_ctrl_unit: RTL and testbench
===================================

# hazard_ctrl_unit

Parametrised hazard and forwarding controller for the 5-stage pipeline (IF, ID, EX, MEM, WB) with configurable register-file and data width. It detects RAW hazards for the instruction in ID and drives two forwarding muxes from EX/MEM and MEM/WB, with priority and write-enable qualification. It also runs a multi-cycle load-use stall FSM, sequences branch flushes, freezes the pipe on a data-memory wait, and keeps saturating stall and flush performance counters.

## Interface
Parameters:
- DATA_W, 32, datapath width
- REG_AW, 4, register address width
- LOAD_LAT, 1, load-use stall cycles inserted per hazard, legal range 1..7
- CNT_W, 16, performance counter width
- ZERO_REG, 1, if 1 then register 0 is hardwired and never forwarded or hazarded

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_ra, id_rb  in  REG_AW  source registers of the instruction in ID
- id_ra_used, id_rb_used  in  1  source actually read
- ex_rd  in  REG_AW  destination of the instruction in EX (ID/EX register)
- ex_we, ex_load  in  1  EX instruction writes a register / is a load
- exmem_rd, exmem_we, exmem_load  in  REG_AW,1,1  EX/MEM destination info
- exmem_alu_result  in  DATA_W  ALU result held in EX/MEM
- memwb_rd, memwb_we  in  REG_AW,1  MEM/WB destination info
- memwb_result  in  DATA_W  writeback value
- branch_taken  in  1  taken branch resolved in EX
- mem_busy  in  1  data memory not ready
- fwd_sel_a, fwd_sel_b  out  2  00 regfile, 01 EX/MEM, 10 MEM/WB
- fwd_data_a, fwd_data_b  out  DATA_W  selected forward value (memwb_result when sel=00, don't-care)
- stall_if  out  1  hold PC and IF/ID
- bubble_ex  out  1  load NOP into ID/EX
- freeze  out  1  hold all pipeline registers
- flush_ifid, flush_idex  out  1  clear the respective register
- lu_active  out  1  FSM in LU_STALL
- stall_count, flush_count  out  CNT_W  saturating event counters

## Operation
- Source match x: ID source used, stage we=1, rd equal, and not (ZERO_REG=1 and rd=0).
- Forwarding, per operand: EX/MEM match with exmem_load=0 gives sel 01. Otherwise a MEM/WB match gives 10. Otherwise 00. EX/MEM has priority over MEM/WB.
- Load-use hazard: ex_load, ex_we, a source match against ex_rd, state IDLE, mem_busy=0, branch_taken=0.
- FSM states:
  - IDLE: a hazard asserts stall_if and bubble_ex this cycle, loads cnt=LOAD_LAT-1, and goes to LU_STALL if LOAD_LAT>1, else stays IDLE.
  - LU_STALL: asserts stall_if and bubble_ex and decrements cnt. At cnt=0 it asserts for that last cycle and returns to IDLE.
- The regfile is write-before-read, so after LOAD_LAT>1 the consumer reads correct data via sel 00 or 10.
- Branch: if branch_taken=1 and mem_busy=0, flush_ifid and flush_idex assert, stall_if and bubble_ex stay 0, and the FSM aborts to IDLE with cnt=0. Branch beats load-use.
- mem_busy=1: freeze=1 and stall_if=1. Flush and bubble_ex stay 0. FSM state and cnt hold. branch_taken stays asserted by EX until freeze releases.
- Counters:
  - stall_count increments on each cycle with stall_if=1.
  - flush_count increments on each cycle with flush_ifid=1.
  - Both saturate at 2^CNT_W-1.

## Timing
- Forwarding, stall, flush and freeze outputs are combinational from inputs plus current state. There is no added latency.
- FSM, cnt and counters update on the clk edge.
- Reset, while rst=1 and after it:
  - state IDLE, cnt 0, counters 0.
  - stall_if, bubble_ex, freeze, flush_* and lu_active are forced 0, and fwd_sel_* is 00.
  - rst mid-stall aborts immediately.
- A load-use hazard yields exactly LOAD_LAT consecutive stall_if cycles, excluding mem_busy cycles, which extend the stall without consuming cnt.
- Reset has priority over mem_busy, which has priority over branch_taken, which has priority over load-use.

## Test plan
- Forward priority: ID ra=3. EX/MEM rd=3 we=1 alu=0xAAAA0000. MEM/WB rd=3 result=0x5555. Expect fwd_sel_a=01 and fwd_data_a=0xAAAA0000. With exmem_we=0, expect sel 10 and data 0x5555.
- Zero register: ra=0, exmem_rd=0, we=1, ZERO_REG=1. Expect sel 00 and no stall.
- Load-use, LOAD_LAT=3: ex_load, ex_rd=5, id_rb=5 used. Expect stall_if and bubble_ex high for exactly 3 cycles, lu_active high for cycles 2-3, and stall_count=3.
- Branch abort: in LU_STALL cycle 2, raise branch_taken. Expect flush_ifid and flush_idex=1 with stall_if=0 that cycle, IDLE next cycle, and flush_count=1.
- mem_busy during LU_STALL with LOAD_LAT=2: 4 busy cycles inserted. Expect freeze=1 for 4 cycles and 6 stall_if cycles in total.
- Saturation and reset: with CNT_W=4, 20 stall cycles give stall_count=15. Pulsing rst mid-stall gives all outputs 0 the same cycle and counters 0 after the edge.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline.
// Ports: ID sources, EX / EX-MEM / MEM-WB destination info, branch_taken, mem_busy in;
//        fwd_sel_*/fwd_data_*, stall_if, bubble_ex, freeze, flush_*, lu_active, counters out.
module hazard_ctrl_unit #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 4,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_ra,
    input  logic [REG_AW-1:0] id_rb,
    input  logic              id_ra_used,
    input  logic              id_rb_used,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_we,
    input  logic              ex_load,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_we,
    input  logic              exmem_load,
    input  logic [DATA_W-1:0] exmem_alu_result,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_we,
    input  logic [DATA_W-1:0] memwb_result,
    input  logic              branch_taken,
    input  logic              mem_busy,
    output logic [1:0]        fwd_sel_a,
    output logic [1:0]        fwd_sel_b,
    output logic [DATA_W-1:0] fwd_data_a,
    output logic [DATA_W-1:0] fwd_data_b,
    output logic              stall_if,
    output logic              bubble_ex,
    output logic              freeze,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              lu_active,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    typedef enum logic {
        IDLE,
        LU_STALL
    } state_e;

    localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

    state_e           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;
    logic             lu_hazard;

    function automatic logic src_match(
        input logic [REG_AW-1:0] src,
        input logic              used,
        input logic [REG_AW-1:0] rd,
        input logic              we
    );
        return used && we && (rd == src) && !((ZERO_REG == 1) && (rd == '0));
    endfunction

    // Forwarding: EX/MEM wins over MEM/WB; a load in EX/MEM has no data yet.
    always_comb begin
        fwd_sel_a = 2'b00;
        fwd_sel_b = 2'b00;
        if (!rst) begin
            if (src_match(id_ra, id_ra_used, exmem_rd, exmem_we) && !exmem_load)
                fwd_sel_a = 2'b01;
            else if (src_match(id_ra, id_ra_used, memwb_rd, memwb_we))
                fwd_sel_a = 2'b10;
            if (src_match(id_rb, id_rb_used, exmem_rd, exmem_we) && !exmem_load)
                fwd_sel_b = 2'b01;
            else if (src_match(id_rb, id_rb_used, memwb_rd, memwb_we))
                fwd_sel_b = 2'b10;
        end
        fwd_data_a = (fwd_sel_a == 2'b01) ? exmem_alu_result : memwb_result;
        fwd_data_b = (fwd_sel_b == 2'b01) ? exmem_alu_result : memwb_result;
    end

    assign lu_hazard = ex_load &&
                       (src_match(id_ra, id_ra_used, ex_rd, ex_we) ||
                        src_match(id_rb, id_rb_used, ex_rd, ex_we));

    // Priority: reset > mem_busy > branch > ongoing stall > new load-use.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall_if   = 1'b0;
        bubble_ex  = 1'b0;
        freeze     = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        if (rst) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (mem_busy) begin
            freeze   = 1'b1;
            stall_if = 1'b1;
        end else if (branch_taken) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            state_d    = IDLE;
            cnt_d      = '0;
        end else if (state_q == LU_STALL) begin
            stall_if  = 1'b1;
            bubble_ex = 1'b1;
            // Last owed cycle once the count would reach zero.
            if (cnt_q <= 3'd1) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
        end else if (lu_hazard) begin
            stall_if  = 1'b1;
            bubble_ex = 1'b1;
            cnt_d     = LAT_M1;
            state_d   = (LOAD_LAT > 1) ? LU_STALL : IDLE;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stall_if && (stall_count_q != '1))
            stall_count_d = stall_count_q + 1'b1;
        if (flush_ifid && (flush_count_q != '1))
            flush_count_d = flush_count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign lu_active   = !rst && (state_q == LU_STALL);
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit.
// Directed scenarios plus randomized traffic against a stall-debt model.
module tb_hazard_ctrl_unit;

    localparam int DW  = 32;
    localparam int AW  = 4;
    localparam int LL  = 3;
    localparam int CW  = 4;
    localparam int ZR  = 1;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] id_ra, id_rb, ex_rd, exmem_rd, memwb_rd;
    logic          id_ra_used, id_rb_used, ex_we, ex_load;
    logic          exmem_we, exmem_load, memwb_we, branch_taken, mem_busy;
    logic [DW-1:0] exmem_alu_result, memwb_result;
    logic [1:0]    fwd_sel_a, fwd_sel_b;
    logic [DW-1:0] fwd_data_a, fwd_data_b;
    logic          stall_if, bubble_ex, freeze, flush_ifid, flush_idex, lu_active;
    logic [CW-1:0] stall_count, flush_count;

    int checks   = 0;
    int failures = 0;
    int m_rem    = 0;
    int m_stalls = 0;
    int m_flush  = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(
        .DATA_W(DW), .REG_AW(AW), .LOAD_LAT(LL), .CNT_W(CW), .ZERO_REG(ZR)
    ) dut (
        .clk(clk), .rst(rst),
        .id_ra(id_ra), .id_rb(id_rb),
        .id_ra_used(id_ra_used), .id_rb_used(id_rb_used),
        .ex_rd(ex_rd), .ex_we(ex_we), .ex_load(ex_load),
        .exmem_rd(exmem_rd), .exmem_we(exmem_we), .exmem_load(exmem_load),
        .exmem_alu_result(exmem_alu_result),
        .memwb_rd(memwb_rd), .memwb_we(memwb_we), .memwb_result(memwb_result),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
        .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b),
        .stall_if(stall_if), .bubble_ex(bubble_ex), .freeze(freeze),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .lu_active(lu_active),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---- reference model: outstanding stall debt m_rem ----
    function automatic bit hit(input logic [AW-1:0] src, input logic used,
                               input logic [AW-1:0] rd, input logic we);
        return used && we && (rd == src) && !(ZR == 1 && rd == 0);
    endfunction

    function automatic int sel_of(input logic [AW-1:0] src, input logic used);
        if (rst) return 0;
        if (hit(src, used, exmem_rd, exmem_we) && !exmem_load) return 1;
        if (hit(src, used, memwb_rd, memwb_we)) return 2;
        return 0;
    endfunction

    // 0 reset, 1 busy, 2 branch, 3 owed stall, 4 new load-use, 5 nothing
    function automatic int mode();
        if (rst) return 0;
        if (mem_busy) return 1;
        if (branch_taken) return 2;
        if (m_rem > 0) return 3;
        if (ex_load && (hit(id_ra, id_ra_used, ex_rd, ex_we) ||
                        hit(id_rb, id_rb_used, ex_rd, ex_we))) return 4;
        return 5;
    endfunction

    always @(posedge clk) begin
        int md;
        md = mode();
        case (md)
            0: begin m_rem = 0; m_stalls = 0; m_flush = 0; end
            1: if (m_stalls < SAT) m_stalls++;
            2: begin m_rem = 0; if (m_flush < SAT) m_flush++; end
            3: begin m_rem--; if (m_stalls < SAT) m_stalls++; end
            4: begin m_rem = LL - 1; if (m_stalls < SAT) m_stalls++; end
            default: ;
        endcase
    end

    always @(negedge clk) begin
        int md, sa, sb;
        if (chk_en) begin
            md = mode();
            sa = sel_of(id_ra, id_ra_used);
            sb = sel_of(id_rb, id_rb_used);
            check("sel_a", 64'(fwd_sel_a), 64'(sa));
            check("sel_b", 64'(fwd_sel_b), 64'(sb));
            if (sa == 1) check("data_a", 64'(fwd_data_a), 64'(exmem_alu_result));
            else if (sa == 2) check("data_a", 64'(fwd_data_a), 64'(memwb_result));
            if (sb == 1) check("data_b", 64'(fwd_data_b), 64'(exmem_alu_result));
            else if (sb == 2) check("data_b", 64'(fwd_data_b), 64'(memwb_result));
            check("stall_if", 64'(stall_if), 64'(md == 1 || md == 3 || md == 4));
            check("bubble_ex", 64'(bubble_ex), 64'(md == 3 || md == 4));
            check("freeze", 64'(freeze), 64'(md == 1));
            check("flush_ifid", 64'(flush_ifid), 64'(md == 2));
            check("flush_idex", 64'(flush_idex), 64'(md == 2));
            check("lu_active", 64'(lu_active), 64'(!rst && m_rem > 0));
            check("stall_count", 64'(stall_count), 64'(m_stalls));
            check("flush_count", 64'(flush_count), 64'(m_flush));
        end
    end

    // ---- stimulus helpers ----
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        id_ra = '0; id_rb = '0; id_ra_used = 0; id_rb_used = 0;
        ex_rd = '0; ex_we = 0; ex_load = 0;
        exmem_rd = '0; exmem_we = 0; exmem_load = 0; exmem_alu_result = '0;
        memwb_rd = '0; memwb_we = 0; memwb_result = '0;
        branch_taken = 0; mem_busy = 0;
    endtask

    task automatic pulse_rst();
        idle_in();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic set_lu();
        ex_load = 1; ex_we = 1; ex_rd = 4'd5;
        id_rb = 4'd5; id_rb_used = 1;
    endtask

    task automatic rand_in();
        rst          = ($urandom_range(0, 59) == 0);
        id_ra        = AW'($urandom_range(0, 3));
        id_rb        = AW'($urandom_range(0, 3));
        id_ra_used   = ($urandom_range(0, 3) != 0);
        id_rb_used   = ($urandom_range(0, 3) != 0);
        ex_rd        = AW'($urandom_range(0, 3));
        ex_we        = ($urandom_range(0, 3) != 0);
        ex_load      = ($urandom_range(0, 2) == 0);
        exmem_rd     = AW'($urandom_range(0, 3));
        exmem_we     = ($urandom_range(0, 2) != 0);
        exmem_load   = ($urandom_range(0, 3) == 0);
        memwb_rd     = AW'($urandom_range(0, 3));
        memwb_we     = ($urandom_range(0, 2) != 0);
        exmem_alu_result = DW'($urandom());
        memwb_result     = DW'($urandom());
        branch_taken = ($urandom_range(0, 9) == 0);
        mem_busy     = ($urandom_range(0, 5) == 0);
    endtask

    initial begin
        int n_st, n_fz;
        idle_in();
        rst = 1;
        // reset forces outputs low even with a hazard and a forward match present
        set_lu();
        id_ra = 4'd3; id_ra_used = 1; exmem_rd = 4'd3; exmem_we = 1;
        step();
        step();
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_stall", 64'(stall_if), 64'd0);
        check("rst_sel_a", 64'(fwd_sel_a), 64'd0);
        check("rst_cnt", 64'(stall_count), 64'd0);
        pulse_rst();

        // forwarding priority
        id_ra = 4'd3; id_ra_used = 1;
        exmem_rd = 4'd3; exmem_we = 1; exmem_alu_result = 32'hAAAA0000;
        memwb_rd = 4'd3; memwb_we = 1; memwb_result = 32'h5555;
        @(negedge clk);
        check("fwd_pri_sel", 64'(fwd_sel_a), 64'd1);
        check("fwd_pri_data", 64'(fwd_data_a), 64'hAAAA0000);
        step();
        exmem_we = 0;
        @(negedge clk);
        check("fwd_wb_sel", 64'(fwd_sel_a), 64'd2);
        check("fwd_wb_data", 64'(fwd_data_a), 64'h5555);
        step();
        exmem_we = 1; exmem_load = 1;
        @(negedge clk);
        check("fwd_ld_sel", 64'(fwd_sel_a), 64'd2);
        step();

        // zero register never forwards or hazards
        idle_in();
        id_ra = '0; id_ra_used = 1; exmem_rd = '0; exmem_we = 1;
        ex_load = 1; ex_we = 1; ex_rd = '0;
        @(negedge clk);
        check("zero_sel", 64'(fwd_sel_a), 64'd0);
        check("zero_stall", 64'(stall_if), 64'd0);
        step();

        // load-use: exactly LL stall cycles
        pulse_rst();
        set_lu();
        @(negedge clk);
        check("lu_c1_stall", 64'(stall_if), 64'd1);
        check("lu_c1_bub", 64'(bubble_ex), 64'd1);
        check("lu_c1_act", 64'(lu_active), 64'd0);
        step();
        ex_load = 0; ex_we = 0;
        @(negedge clk);
        check("lu_c2_stall", 64'(stall_if), 64'd1);
        check("lu_c2_act", 64'(lu_active), 64'd1);
        step();
        @(negedge clk);
        check("lu_c3_stall", 64'(stall_if), 64'd1);
        check("lu_c3_act", 64'(lu_active), 64'd1);
        step();
        @(negedge clk);
        check("lu_c4_stall", 64'(stall_if), 64'd0);
        check("lu_c4_act", 64'(lu_active), 64'd0);
        check("lu_count", 64'(stall_count), 64'd3);

        // branch aborts a load-use stall
        pulse_rst();
        set_lu();
        step();
        ex_load = 0; ex_we = 0; branch_taken = 1;
        @(negedge clk);
        check("br_flush_ifid", 64'(flush_ifid), 64'd1);
        check("br_flush_idex", 64'(flush_idex), 64'd1);
        check("br_stall", 64'(stall_if), 64'd0);
        step();
        branch_taken = 0;
        @(negedge clk);
        check("br_idle", 64'(lu_active), 64'd0);
        check("br_after_stall", 64'(stall_if), 64'd0);
        check("br_fcount", 64'(flush_count), 64'd1);

        // mem_busy extends the stall without consuming it
        pulse_rst();
        set_lu();
        n_st = 0; n_fz = 0;
        @(negedge clk);
        n_st += int'(stall_if);
        step();
        ex_load = 0; ex_we = 0; mem_busy = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_st += int'(stall_if);
            n_fz += int'(freeze);
            step();
        end
        mem_busy = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_st += int'(stall_if);
            n_fz += int'(freeze);
            step();
        end
        @(negedge clk);
        check("busy_stalls", 64'(n_st), 64'd7);
        check("busy_freezes", 64'(n_fz), 64'd4);
        check("busy_count", 64'(stall_count), 64'd7);

        // saturation after 20 stall cycles
        pulse_rst();
        mem_busy = 1;
        for (int i = 0; i < 20; i++) step();
        mem_busy = 0;
        @(negedge clk);
        check("sat_count", 64'(stall_count), 64'd15);

        // reset in the middle of a stall
        set_lu();
        step();
        ex_load = 0; ex_we = 0;
        step();
        rst = 1; mem_busy = 1;
        id_ra = 4'd3; id_ra_used = 1; exmem_rd = 4'd3; exmem_we = 1;
        @(negedge clk);
        check("mrst_stall", 64'(stall_if), 64'd0);
        check("mrst_freeze", 64'(freeze), 64'd0);
        check("mrst_bubble", 64'(bubble_ex), 64'd0);
        check("mrst_act", 64'(lu_active), 64'd0);
        check("mrst_sel", 64'(fwd_sel_a), 64'd0);
        step();
        idle_in();
        rst = 0;
        @(negedge clk);
        check("mrst_scount", 64'(stall_count), 64'd0);
        check("mrst_fcount", 64'(flush_count), 64'd0);
        step();

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rand_in();
            step();
        end
        idle_in();
        rst = 0;
        step();
        @(negedge clk);
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
